// File: rtl/mac_result_requant.sv
// mac_result_requant: requantise signed MAC results to int8 and pack four per word into an output FIFO.
// Define REQ_ROUND_EN for round-half-up before the shift; by default the shift truncates toward -inf.
module mac_result_requant #(
   parameter int W_ACC      = 32,
   parameter int SCALE_W    = 16,
   parameter int SHIFT_W    = 5,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [W_ACC-1:0]   in_acc,
   input  logic               in_flush,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic [7:0]         cfg_zp,
   output logic               out_valid,
   output logic [31:0]        out_data,
   input  logic               out_ready,
   output logic               overflow
);
   localparam int PW = W_ACC + SCALE_W + 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic signed [PW:0] MAXV = 127;
   localparam logic signed [PW:0] MINV = -128;

   logic signed [PW-1:0] prod_d, prod_q;
   logic                 s1_valid_q, s1_flush_q;
   logic signed [PW:0]   r, v, zp_ext;
   logic [7:0]           byte_d, byte_q;
   logic                 s2_valid_q, s2_flush_q;
   logic [31:0]          word_d, word_q, new_word;
   logic [2:0]           cnt_d, cnt_q, new_cnt;
   logic                 push, push_ok, pop, full;
   logic [AW:0]          wp_d, wp_q, rp_d, rp_q;
   logic                 overflow_d, overflow_q;
   logic [31:0]          mem_q [FIFO_DEPTH];
`ifdef REQ_ROUND_EN
   logic signed [PW:0]   rnd;
`endif

   always_comb begin
      prod_d = $signed(in_acc) * $signed({1'b0, cfg_scale});
`ifdef REQ_ROUND_EN
      rnd    = (cfg_shift == '0) ? '0 : {{PW{1'b0}}, 1'b1} << (cfg_shift - SHIFT_W'(1));
      r      = ($signed({prod_q[PW-1], prod_q}) + rnd) >>> cfg_shift;
`else
      r      = $signed({prod_q[PW-1], prod_q}) >>> cfg_shift;
`endif
      zp_ext = {{(PW - 7){cfg_zp[7]}}, cfg_zp};
      v      = r + zp_ext;
      byte_d = (v > MAXV) ? 8'h7f : (v < MINV) ? 8'h80 : v[7:0];
   end

   // Packer: a flush closes the word including any lane written in the same cycle.
   always_comb begin
      new_word = s2_valid_q ? (word_q | ({24'b0, byte_q} << {cnt_q[1:0], 3'b000})) : word_q;
      new_cnt  = cnt_q + {2'b0, s2_valid_q};
      push     = new_cnt[2] | (s2_flush_q & (new_cnt != 3'd0));
      word_d   = push ? '0 : new_word;
      cnt_d    = push ? '0 : new_cnt;
   end

   always_comb begin
      out_valid  = wp_q != rp_q;
      full       = (wp_q[AW-1:0] == rp_q[AW-1:0]) & (wp_q[AW] != rp_q[AW]);
      pop        = out_valid & out_ready;
      push_ok    = push & (~full | pop);
      wp_d       = wp_q + (AW + 1)'(push_ok);
      rp_d       = rp_q + (AW + 1)'(pop);
      overflow_d = overflow_q | (push & full & ~pop);
      out_data   = out_valid ? mem_q[rp_q[AW-1:0]] : '0;
      overflow   = overflow_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_flush_q <= 1'b0;
         byte_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_flush_q <= 1'b0;
         word_q     <= '0;
         cnt_q      <= '0;
         wp_q       <= '0;
         rp_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         prod_q     <= prod_d;
         s1_valid_q <= in_valid;
         s1_flush_q <= in_flush;
         byte_q     <= byte_d;
         s2_valid_q <= s1_valid_q;
         s2_flush_q <= s1_flush_q;
         word_q     <= word_d;
         cnt_q      <= cnt_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wp_q[AW-1:0]] <= new_word;
   end
endmodule

// File: tb/tb_mac_result_requant.sv
// tb_mac_result_requant: directed vectors against a behavioural requantise/pack/FIFO model plus literal checks.
module tb_mac_result_requant;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic signed [31:0] in_acc = '0;
   logic               in_flush = 1'b0;
   logic [15:0]        cfg_scale = 16'd1;
   logic [4:0]         cfg_shift = '0;
   logic signed [7:0]  cfg_zp = '0;
   logic               out_valid;
   logic [31:0]        out_data;
   logic               out_ready = 1'b0;
   logic               overflow;

   int vectors = 0;
   int errs = 0;

   logic [31:0] q_m[$];
   logic [7:0]  lanes_m[4];
   int          cnt_m;
   bit          ovf_m;
   bit          ev_v[2];
   logic [31:0] ev_w[2];

   mac_result_requant dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_acc(in_acc), .in_flush(in_flush),
      .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] requant(input logic signed [31:0] a);
      longint p, s, z, v;
      s = cfg_scale;
      z = cfg_zp;
      p = longint'(a) * s;
`ifdef REQ_ROUND_EN
      if (cfg_shift > 0) p = p + (longint'(1) << (cfg_shift - 1));
`endif
      v = (p >>> cfg_shift) + z;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: words formed from the inputs at one edge enter the FIFO two edges later.
   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         q_m.delete();
         cnt_m = 0;
         ovf_m = 0;
         ev_v[0] = 0;
         ev_v[1] = 0;
         for (int i = 0; i < 4; i++) lanes_m[i] = '0;
      end else begin
         bit pop_m;
         bit nv;
         logic [31:0] nw;
         pop_m = (q_m.size() != 0) && out_ready;
         nv = 0;
         nw = '0;
         if (in_valid) begin
            lanes_m[cnt_m] = requant(in_acc);
            cnt_m++;
         end
         if (cnt_m == 4 || (in_flush && cnt_m > 0)) begin
            nv = 1;
            nw = {lanes_m[3], lanes_m[2], lanes_m[1], lanes_m[0]};
            cnt_m = 0;
            for (int i = 0; i < 4; i++) lanes_m[i] = '0;
         end
         if (pop_m) void'(q_m.pop_front());
         if (ev_v[1]) begin
            if (q_m.size() < 8) q_m.push_back(ev_w[1]);
            else ovf_m = 1;
         end
         ev_v[1] = ev_v[0];
         ev_w[1] = ev_w[0];
         ev_v[0] = nv;
         ev_w[0] = nw;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("model_valid", {31'b0, out_valid}, {31'b0, q_m.size() != 0});
         chk("model_data", out_data, (q_m.size() != 0) ? q_m[0] : 32'h0);
         chk("model_overflow", {31'b0, overflow}, {31'b0, ovf_m});
      end
   end

   task automatic beat(input logic signed [31:0] a, input logic f);
      @(negedge clk);
      in_valid = 1'b1;
      in_acc = a;
      in_flush = f;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      in_flush = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic pop1();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_valid", {31'b0, out_valid}, 32'd0);
      chk("reset_data", out_data, 32'd0);
      chk("reset_overflow", {31'b0, overflow}, 32'd0);
      rst = 1'b0;
      idle(2);

      beat(1, 0); beat(2, 0); beat(3, 0); beat(4, 0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_k", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_k1", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_k2", {31'b0, out_valid}, 32'd1);
      chk("word_1234", out_data, 32'h04030201);
      idle(2);
      chk("hold_head", out_data, 32'h04030201);
      pop1();

      beat(1000, 0); beat(-1000, 0); beat(127, 0); beat(-128, 0);
      idle(4);
      chk("saturate", out_data, 32'h807f807f);
      pop1();

      cfg_shift = 5'd2;
      cfg_zp = -8'sd3;
      repeat (4) beat(6, 0);
      idle(4);
`ifdef REQ_ROUND_EN
      chk("round_shift", out_data, 32'hffffffff);
`else
      chk("round_shift", out_data, 32'hfefefefe);
`endif
      pop1();
      cfg_shift = '0;
      cfg_zp = '0;
      idle(2);

      beat(5, 0); beat(6, 0); beat(0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_flush = 1'b1;
      idle(4);
      chk("flush_alone", out_data, 32'h00000605);
      pop1();
      beat(5, 0); beat(6, 0); beat(7, 1);
      idle(4);
      chk("flush_with_beat", out_data, 32'h00070605);
      pop1();
      @(negedge clk);
      in_flush = 1'b1;
      idle(4);
      chk("flush_noop", {31'b0, out_valid}, 32'd0);

      for (int i = 1; i <= 36; i++) beat(i, 0);
      idle(4);
      chk("ovf_set", {31'b0, overflow}, 32'd1);
      chk("ovf_head", out_data, 32'h04030201);
      @(negedge clk);
      out_ready = 1'b1;
      repeat (7) @(negedge clk);
      chk("ovf_last", out_data, 32'h201f1e1d);
      repeat (3) @(negedge clk);
      out_ready = 1'b0;
      chk("ovf_drained", {31'b0, out_valid}, 32'd0);

      beat(1, 0); beat(2, 0);
      idle(1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) beat(9, 0);
      idle(4);
      chk("rst_word", out_data, 32'h09090909);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      pop1();
      idle(2);
      chk("rst_single", {31'b0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
